uart_rx_frame_counter: RTL and testbench
========================================

UART_RX_FRAME_COUNTER -- requirements
Module: uart_rx_frame_counter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data bits per frame, legal range 5..16.
REQ-002 Parameter PRESCALE_WIDTH, default 6: width of prescale and edge_cnt.
REQ-003 Parameter BIT_CNT_WIDTH, default 5: width of bit_cnt; must hold values up to DATA_WIDTH+3.
REQ-004 clck  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  frame counting enable; the 0->1 transition starts a frame.
REQ-007 prescale  in  PRESCALE_WIDTH  clock cycles per bit; legal range 4..2^PRESCALE_WIDTH-1.
REQ-008 par_en  in  1  adds one parity bit to the frame.
REQ-009 stop2  in  1  adds a second stop bit to the frame.
REQ-010 edge_cnt  out  PRESCALE_WIDTH  registered position within the current bit, 0..P-1.
REQ-011 bit_cnt  out  BIT_CNT_WIDTH  registered index of the current bit in the frame, 0..F-1.
REQ-012 sample_stb  out  1  combinational strobe marking the three mid-bit sample points.
REQ-013 sample_idx  out  2  combinational index of the sample point: 0, 1 or 2.
REQ-014 bit_done  out  1  registered one-cycle pulse at each bit boundary.
REQ-015 frame_done  out  1  registered one-cycle pulse at the end of each frame.
REQ-016 cfg_err  out  1  registered flag: the captured prescale was illegal.

Function
REQ-017 Config capture: when enable=1 and run=0 at an edge, the block latches prescale as P and par_en, stop2 into shadow registers.
REQ-018 At that capture edge, run is set to 1 only if P>=4; otherwise cfg_err is set to 1 and run stays 0.
REQ-019 While run=1, later changes on prescale, par_en and stop2 have no effect until the next capture.
REQ-020 Frame length F = 1 + DATA_WIDTH + par_en + 1 + stop2, computed from the latched values.
REQ-021 edge_cnt and bit_cnt are 0 after the capture edge; each later edge with run=1 and enable=1 increments edge_cnt.
REQ-022 When edge_cnt==P-1: edge_cnt goes to 0 and bit_done is 1 for the next cycle.
REQ-023 At that same edge, bit_cnt increments if bit_cnt<F-1.
REQ-024 If bit_cnt==F-1 at that edge: bit_cnt goes to 0 and frame_done is 1 for the next cycle.
REQ-025 Continuous framing: when enable stays 1 after frame_done, the next frame starts immediately with the same latched config and no re-capture.
REQ-026 Mid-bit point M = P>>1 (floor).
REQ-027 sample_stb = run & enable & (edge_cnt is M-1, M or M+1).
REQ-028 sample_idx = edge_cnt-(M-1) while sample_stb=1, else 0.
REQ-029 Enable drop: an edge with enable=0 clears run, edge_cnt and bit_cnt to 0, with no bit_done or frame_done.
REQ-030 A new 0->1 transition on enable re-captures the config (REQ-017).
REQ-031 cfg_err stays 1 until the next capture with a legal prescale, or until reset.
REQ-032 bit_done and frame_done are never asserted while run=0.
REQ-033 All counter arithmetic is modular within the declared widths.
REQ-034 No combinational path exists from enable, prescale, par_en or stop2 to the registered outputs.

Reset
REQ-035 When rst=0, asynchronously: edge_cnt=0, bit_cnt=0, bit_done=0, frame_done=0, cfg_err=0, run=0, shadow config=0.
REQ-036 sample_stb is 0 during reset.
REQ-037 After reset release, the block waits for enable=1 before counting.
REQ-038 Reset asserted mid-frame aborts the frame immediately, with no done pulses.

Verification
REQ-039 Basic frame: P=8, DATA_WIDTH=8, par_en=0, stop2=0, enable held 1 -> bit_done every 8 cycles; frame_done 80 edges after capture; bit_cnt sequence 0..9 then 0.
REQ-040 Sample points: P=8 -> sample_stb at edge_cnt 3, 4, 5 with sample_idx 0, 1, 2; P=9 -> at edge_cnt 3, 4, 5 (M=4).
REQ-041 Extended frame: P=16, par_en=1, stop2=1 -> F=12; frame_done 192 edges after capture; second frame follows back-to-back without re-capture.
REQ-042 Config change mid-frame: P=8 captured, then prescale driven to 20 at bit 3 -> bit timing stays 8 cycles until enable toggles; the new capture uses 20.
REQ-043 Illegal config: prescale=3 at capture -> cfg_err=1, counters stay 0, no pulses; a re-enable with prescale=4 clears cfg_err and counting starts.
REQ-044 Aborts: enable=0 at bit_cnt=5, edge_cnt=2 -> next cycle all counters 0, no frame_done; rst=0 mid-frame -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/uart_rx_frame_counter_if.sv
// Control and status bundle for the UART receive frame counter.
// The master drives frame enable and configuration; the slave returns counter state.
interface uart_rx_frame_counter_if #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = 5
);
    logic                      enable;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      par_en;
    logic                      stop2;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
    logic                      sample_stb;
    logic [1:0]                sample_idx;
    logic                      bit_done;
    logic                      frame_done;
    logic                      cfg_err;

    modport master (
        output enable, prescale, par_en, stop2,
        input  edge_cnt, bit_cnt, sample_stb, sample_idx, bit_done, frame_done, cfg_err
    );

    modport slave (
        input  enable, prescale, par_en, stop2,
        output edge_cnt, bit_cnt, sample_stb, sample_idx, bit_done, frame_done, cfg_err
    );
endinterface

// File: rtl/uart_rx_frame_counter.sv
// Bit/frame timing counter for a UART receiver: tracks the position inside each bit
// and frame from a prescale latched at frame start, and flags the three mid-bit samples.
module uart_rx_frame_counter #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = 5
) (
    input  logic clck,
    input  logic rst,
    uart_rx_frame_counter_if.slave bus
);
    localparam logic [BIT_CNT_WIDTH-1:0]  BASE_LAST = BIT_CNT_WIDTH'(DATA_WIDTH + 1);
    localparam logic [PRESCALE_WIDTH-1:0] MIN_PRESCALE = PRESCALE_WIDTH'(4);
    localparam logic [PRESCALE_WIDTH-1:0] ONE_P = PRESCALE_WIDTH'(1);
    localparam logic [BIT_CNT_WIDTH-1:0]  ONE_B = BIT_CNT_WIDTH'(1);

    logic                      run_q, run_d;
    logic [PRESCALE_WIDTH-1:0] p_q, p_d;
    logic                      par_q, par_d;
    logic                      stop2_q, stop2_d;
    logic [PRESCALE_WIDTH-1:0] edge_q, edge_d;
    logic [BIT_CNT_WIDTH-1:0]  bit_q, bit_d;
    logic                      bit_done_q, bit_done_d;
    logic                      frame_done_q, frame_done_d;
    logic                      cfg_err_q, cfg_err_d;

    logic [BIT_CNT_WIDTH-1:0]  last_bit;
    logic [PRESCALE_WIDTH-1:0] mid;
    logic [PRESCALE_WIDTH-1:0] rel;

    // Index of the final stop bit: start + data + optional parity + stop (+ second stop).
    assign last_bit = BASE_LAST + BIT_CNT_WIDTH'(par_q) + BIT_CNT_WIDTH'(stop2_q);

    always_comb begin
        run_d        = run_q;
        p_d          = p_q;
        par_d        = par_q;
        stop2_d      = stop2_q;
        edge_d       = edge_q;
        bit_d        = bit_q;
        cfg_err_d    = cfg_err_q;
        bit_done_d   = 1'b0;
        frame_done_d = 1'b0;
        if (!bus.enable) begin
            run_d  = 1'b0;
            edge_d = '0;
            bit_d  = '0;
        end else if (!run_q) begin
            p_d       = bus.prescale;
            par_d     = bus.par_en;
            stop2_d   = bus.stop2;
            edge_d    = '0;
            bit_d     = '0;
            run_d     = (bus.prescale >= MIN_PRESCALE);
            cfg_err_d = (bus.prescale < MIN_PRESCALE);
        end else if (edge_q == p_q - ONE_P) begin
            edge_d     = '0;
            bit_done_d = 1'b1;
            if (bit_q == last_bit) begin
                bit_d        = '0;
                frame_done_d = 1'b1;
            end else begin
                bit_d = bit_q + ONE_B;
            end
        end else begin
            edge_d = edge_q + ONE_P;
        end
    end

    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            run_q        <= 1'b0;
            p_q          <= '0;
            par_q        <= 1'b0;
            stop2_q      <= 1'b0;
            edge_q       <= '0;
            bit_q        <= '0;
            bit_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            run_q        <= run_d;
            p_q          <= p_d;
            par_q        <= par_d;
            stop2_q      <= stop2_d;
            edge_q       <= edge_d;
            bit_q        <= bit_d;
            bit_done_q   <= bit_done_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    // rel is 0,1,2 exactly when edge_cnt sits at M-1, M, M+1 (modular offset from M-1).
    assign mid = p_q >> 1;
    assign rel = edge_q - mid + ONE_P;

    assign bus.sample_stb = run_q & bus.enable & (rel <= PRESCALE_WIDTH'(2));
    assign bus.sample_idx = bus.sample_stb ? rel[1:0] : 2'd0;
    assign bus.edge_cnt   = edge_q;
    assign bus.bit_cnt    = bit_q;
    assign bus.bit_done   = bit_done_q;
    assign bus.frame_done = frame_done_q;
    assign bus.cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_uart_rx_frame_counter.sv
// Randomized and directed bench for uart_rx_frame_counter against a time-since-capture model.
module tb_uart_rx_frame_counter;
    localparam int DW = 8;
    localparam int PW = 6;
    localparam int BW = 5;

    logic clck = 1'b0;
    logic rst  = 1'b1;
    int   tests = 0;
    int   fails = 0;
    bit   cmp_on = 1'b0;

    uart_rx_frame_counter_if #(.PRESCALE_WIDTH(PW), .BIT_CNT_WIDTH(BW)) bus_if ();

    uart_rx_frame_counter #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW), .BIT_CNT_WIDTH(BW)) dut (
        .clck (clck),
        .rst  (rst),
        .bus  (bus_if.slave)
    );

    always #5 clck = ~clck;

    // Model: cycles since the capture edge plus the latched config; all outputs derive from it.
    bit m_run = 1'b0;
    bit m_cfg = 1'b0;
    int m_t   = 0;
    int m_P   = 0;
    int m_F   = 0;

    always @(posedge clck or negedge rst) begin
        if (!rst) begin
            m_run <= 1'b0; m_cfg <= 1'b0; m_t <= 0; m_P <= 0; m_F <= 0;
        end else if (!bus_if.enable) begin
            m_run <= 1'b0; m_t <= 0;
        end else if (!m_run) begin
            m_P   <= int'(bus_if.prescale);
            m_F   <= DW + 2 + int'(bus_if.par_en) + int'(bus_if.stop2);
            m_t   <= 0;
            m_run <= (bus_if.prescale >= 4);
            m_cfg <= (bus_if.prescale < 4);
        end else begin
            m_t <= m_t + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clck) begin
        if (cmp_on) begin
            int e, b, mid, bd, fd, stb, idx;
            e   = (m_P > 0) ? m_t % m_P : 0;
            b   = (m_P > 0 && m_F > 0) ? (m_t / m_P) % m_F : 0;
            bd  = (m_run && m_t > 0 && e == 0) ? 1 : 0;
            fd  = (m_run && m_t > 0 && (m_t % (m_P * m_F)) == 0) ? 1 : 0;
            mid = m_P / 2;
            stb = (m_run && bus_if.enable && e >= mid - 1 && e <= mid + 1) ? 1 : 0;
            idx = stb ? e - mid + 1 : 0;
            chk("edge_cnt",   int'(bus_if.edge_cnt),   e);
            chk("bit_cnt",    int'(bus_if.bit_cnt),    b);
            chk("bit_done",   int'(bus_if.bit_done),   bd);
            chk("frame_done", int'(bus_if.frame_done), fd);
            chk("cfg_err",    int'(bus_if.cfg_err),    int'(m_cfg));
            chk("sample_stb", int'(bus_if.sample_stb), stb);
            chk("sample_idx", int'(bus_if.sample_idx), idx);
        end
    end

    task automatic step();
        @(posedge clck);
        #2;
    endtask

    task automatic restart(input int p, input bit par, input bit s2);
        bus_if.enable = 1'b0;
        step();
        bus_if.prescale = PW'(p);
        bus_if.par_en   = par;
        bus_if.stop2    = s2;
        bus_if.enable   = 1'b1;
    endtask

    // Starts at the capture edge (k=0); records pulse positions and first-bit sample points.
    task automatic measure(input int maxk, output int bd1, output int fd1, output int fd2,
                           output int mask, output int hi_edge);
        bd1 = -1; fd1 = -1; fd2 = -1; mask = 0; hi_edge = -1;
        for (int k = 0; k <= maxk; k++) begin
            step();
            if (bus_if.sample_stb && bd1 < 0) begin
                mask = mask | (1 << int'(bus_if.edge_cnt));
                if (bus_if.sample_idx == 2'd2 && hi_edge < 0) hi_edge = int'(bus_if.edge_cnt);
            end
            if (bus_if.bit_done && bd1 < 0) bd1 = k;
            if (bus_if.frame_done) begin
                if (fd1 < 0) fd1 = k;
                else if (fd2 < 0) fd2 = k;
            end
        end
    endtask

    initial begin
        int bd1, fd1, fd2, mask, hi, pulses;
        bus_if.enable = 1'b0; bus_if.prescale = '0; bus_if.par_en = 1'b0; bus_if.stop2 = 1'b0;
        #1 rst = 1'b0;
        repeat (3) step();
        cmp_on = 1'b1;
        chk("rst_edge_cnt", int'(bus_if.edge_cnt), 0);
        chk("rst_sample_stb", int'(bus_if.sample_stb), 0);
        rst = 1'b1;
        repeat (3) step();
        chk("idle_bit_cnt", int'(bus_if.bit_cnt), 0);
        chk("idle_cfg_err", int'(bus_if.cfg_err), 0);

        restart(8, 1'b0, 1'b0);
        measure(170, bd1, fd1, fd2, mask, hi);
        chk("p8_first_bit_done", bd1, 8);
        chk("p8_first_frame_done", fd1, 80);
        chk("p8_second_frame_done", fd2, 160);
        chk("p8_sample_mask", mask, 32'h38);
        chk("p8_idx2_edge", hi, 5);

        restart(9, 1'b0, 1'b0);
        measure(20, bd1, fd1, fd2, mask, hi);
        chk("p9_sample_mask", mask, 32'h38);
        chk("p9_first_bit_done", bd1, 9);

        restart(16, 1'b1, 1'b1);
        measure(400, bd1, fd1, fd2, mask, hi);
        chk("p16_first_frame_done", fd1, 192);
        chk("p16_second_frame_done", fd2, 384);

        restart(8, 1'b0, 1'b0);
        fd1 = -1;
        for (int k = 0; k <= 90; k++) begin
            step();
            if (k == 24) bus_if.prescale = PW'(20);
            if (bus_if.frame_done && fd1 < 0) fd1 = k;
        end
        chk("cfgchg_frame_done", fd1, 80);
        restart(20, 1'b0, 1'b0);
        measure(30, bd1, fd1, fd2, mask, hi);
        chk("cfgchg_new_bit_done", bd1, 20);

        restart(3, 1'b0, 1'b0);
        step();
        chk("illegal_cfg_err", int'(bus_if.cfg_err), 1);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            pulses += int'(bus_if.bit_done) + int'(bus_if.frame_done) + int'(bus_if.edge_cnt);
        end
        chk("illegal_no_activity", pulses, 0);
        restart(4, 1'b0, 1'b0);
        chk("illegal_err_held", int'(bus_if.cfg_err), 1);
        measure(6, bd1, fd1, fd2, mask, hi);
        chk("legal_cfg_err_cleared", int'(bus_if.cfg_err), 0);
        chk("legal_first_bit_done", bd1, 4);

        restart(8, 1'b0, 1'b0);
        step();
        for (int k = 1; k <= 42; k++) step();
        chk("abort_bit_cnt", int'(bus_if.bit_cnt), 5);
        chk("abort_edge_cnt", int'(bus_if.edge_cnt), 2);
        bus_if.enable = 1'b0;
        step();
        chk("abort_cleared", int'(bus_if.bit_cnt) + int'(bus_if.edge_cnt) + int'(bus_if.frame_done) + int'(bus_if.bit_done), 0);

        restart(8, 1'b0, 1'b0);
        step();
        for (int k = 1; k <= 24; k++) step();
        chk("pre_rst_bit_done", int'(bus_if.bit_done), 1);
        rst = 1'b0;
        #1;
        chk("async_rst_bit_done", int'(bus_if.bit_done), 0);
        chk("async_rst_bit_cnt", int'(bus_if.bit_cnt), 0);
        #1 rst = 1'b1;
        bus_if.enable = 1'b0;

        for (int i = 0; i < 6000; i++) begin
            step();
            if ($urandom_range(0, 299) == 0) bus_if.enable = ~bus_if.enable;
            if ($urandom_range(0, 9) == 0) bus_if.prescale = PW'($urandom_range(2, 12));
            if ($urandom_range(0, 99) == 0) bus_if.prescale = PW'($urandom_range(13, 63));
            if ($urandom_range(0, 9) == 0) bus_if.par_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) bus_if.stop2 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0 && !bus_if.enable) bus_if.enable = 1'b1;
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b0;
                #2 rst = 1'b1;
            end
        end

        cmp_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
